// File: rtl/fetch_stage.sv
// Fetch stage: PC register, instruction read request, one-entry skid buffer
// and the fetch/decode pipeline latch, governed by a FETCH/HOLD/HALTED FSM.
module fetch_stage #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic [31:0] iload,
    input  logic        stallFD,
    input  logic        flushFD,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    output logic [31:0] FDinst,
    output logic [31:0] FDnpc,
    output logic        FDvalid
);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        HOLD   = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] fd_inst_q, fd_inst_d;
    logic [31:0] fd_npc_q, fd_npc_d;
    logic        fd_valid_q, fd_valid_d;
    logic [31:0] skid_inst_q, skid_inst_d;
    logic [31:0] skid_npc_q, skid_npc_d;
    logic        skid_valid_q, skid_valid_d;
    logic [31:0] pc_plus4;

    // Sequential PC increment wraps modulo 2^32 with no carry out.
    assign pc_plus4 = pc_q + 32'd4;

    // Next-state decision in priority order: halt, redirect, flush, stall, ihit.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        fd_inst_d    = fd_inst_q;
        fd_npc_d     = fd_npc_q;
        fd_valid_d   = fd_valid_q;
        skid_inst_d  = skid_inst_q;
        skid_npc_d   = skid_npc_q;
        skid_valid_d = skid_valid_q;

        if (halt) begin
            state_d      = HALTED;
            fd_inst_d    = 32'd0;
            fd_npc_d     = 32'd0;
            fd_valid_d   = 1'b0;
            skid_valid_d = 1'b0;
        end else if (state_q == HALTED) begin
            state_d = HALTED;
        end else if (redirect) begin
            state_d      = FETCH;
            pc_d         = redirect_pc;
            fd_inst_d    = 32'd0;
            fd_npc_d     = 32'd0;
            fd_valid_d   = 1'b0;
            skid_valid_d = 1'b0;
        end else if (flushFD) begin
            state_d      = FETCH;
            fd_inst_d    = 32'd0;
            fd_npc_d     = 32'd0;
            fd_valid_d   = 1'b0;
            skid_valid_d = 1'b0;
            if (state_q == FETCH && ihit) begin
                pc_d = pc_plus4;
            end
        end else if (state_q == HOLD) begin
            if (!stallFD) begin
                state_d      = FETCH;
                fd_inst_d    = skid_inst_q;
                fd_npc_d     = skid_npc_q;
                fd_valid_d   = skid_valid_q;
                skid_valid_d = 1'b0;
            end
        end else begin
            if (ihit) begin
                pc_d = pc_plus4;
                if (stallFD) begin
                    state_d      = HOLD;
                    skid_inst_d  = iload;
                    skid_npc_d   = pc_plus4;
                    skid_valid_d = 1'b1;
                end else begin
                    fd_inst_d  = iload;
                    fd_npc_d   = pc_plus4;
                    fd_valid_d = 1'b1;
                end
            end else if (!stallFD) begin
                fd_inst_d  = 32'd0;
                fd_npc_d   = 32'd0;
                fd_valid_d = 1'b0;
            end
        end
    end

    // State, PC, latch and skid registers; reset restarts fetch at PC_INIT.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q      <= FETCH;
            pc_q         <= PC_INIT;
            fd_inst_q    <= 32'd0;
            fd_npc_q     <= 32'd0;
            fd_valid_q   <= 1'b0;
            skid_inst_q  <= 32'd0;
            skid_npc_q   <= 32'd0;
            skid_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            fd_inst_q    <= fd_inst_d;
            fd_npc_q     <= fd_npc_d;
            fd_valid_q   <= fd_valid_d;
            skid_inst_q  <= skid_inst_d;
            skid_npc_q   <= skid_npc_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    // Read request comes straight from the state register only.
    assign imemREN  = (state_q == FETCH);
    assign imemaddr = pc_q;
    assign FDinst   = fd_inst_q;
    assign FDnpc    = fd_npc_q;
    assign FDvalid  = fd_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage with a queue of expected output snapshots.
module tb_fetch_stage;

    logic        CLK;
    logic        nRST;
    logic        ihit;
    logic [31:0] iload;
    logic        stallFD;
    logic        flushFD;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic [31:0] FDinst;
    logic [31:0] FDnpc;
    logic        FDvalid;

    typedef struct {
        logic        valid;
        logic [31:0] inst;
        logic [31:0] npc;
        logic [31:0] addr;
        logic        ren;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;

    fetch_stage #(.PC_INIT(32'h0000_0000)) dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .ihit       (ihit),
        .iload      (iload),
        .stallFD    (stallFD),
        .flushFD    (flushFD),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .halt       (halt),
        .imemREN    (imemREN),
        .imemaddr   (imemaddr),
        .FDinst     (FDinst),
        .FDnpc      (FDnpc),
        .FDvalid    (FDvalid)
    );

    // Free-running clock, 10 time units per cycle.
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Instruction words are tagged with the address they were read from.
    function automatic logic [31:0] tagOf(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // Memory model answers whatever address the fetch stage presents.
    assign iload = tagOf(imemaddr);

    // Queue up one expected snapshot of all outputs.
    task automatic pushExp(input logic v, input logic [31:0] inst, input logic [31:0] npc,
                           input logic [31:0] addr, input logic ren);
        exp_t e;
        e.valid = v;
        e.inst  = inst;
        e.npc   = npc;
        e.addr  = addr;
        e.ren   = ren;
        expQ.push_back(e);
    endtask

    // Pop the oldest expectation and compare every output against it.
    task automatic checkOutput(input string name);
        exp_t e;
        if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s queue: got empty expected entry", name);
            return;
        end
        e = expQ.pop_front();
        checks++;
        assert (FDvalid === e.valid) else begin
            errors++;
            $error("[TB] FAIL %s FDvalid: got %b expected %b", name, FDvalid, e.valid);
        end
        checks++;
        assert (FDinst === e.inst) else begin
            errors++;
            $error("[TB] FAIL %s FDinst: got %h expected %h", name, FDinst, e.inst);
        end
        checks++;
        assert (FDnpc === e.npc) else begin
            errors++;
            $error("[TB] FAIL %s FDnpc: got %h expected %h", name, FDnpc, e.npc);
        end
        checks++;
        assert (imemaddr === e.addr) else begin
            errors++;
            $error("[TB] FAIL %s imemaddr: got %h expected %h", name, imemaddr, e.addr);
        end
        checks++;
        assert (imemREN === e.ren) else begin
            errors++;
            $error("[TB] FAIL %s imemREN: got %b expected %b", name, imemREN, e.ren);
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, then compare.
    task automatic applyStimulus(input string name, input logic ih, input logic st,
                                 input logic fl, input logic rd, input logic [31:0] rpc,
                                 input logic hl);
        ihit        = ih;
        stallFD     = st;
        flushFD     = fl;
        redirect    = rd;
        redirect_pc = rpc;
        halt        = hl;
        @(posedge CLK);
        #1;
        checkOutput(name);
    endtask

    // Directed sequence walking through every fetch scenario.
    initial begin
        nRST        = 1'b0;
        ihit        = 1'b0;
        stallFD     = 1'b0;
        flushFD     = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        halt        = 1'b0;

        #12;
        pushExp(1'b0, 32'd0, 32'd0, 32'd0, 1'b1);
        checkOutput("reset");
        @(posedge CLK);
        #1;
        nRST = 1'b1;

        // Streaming fetch from PC 0
        for (int i = 0; i < 4; i++) begin
            pushExp(1'b1, tagOf(32'(4 * i)), 32'(4 * i + 4), 32'(4 * i + 4), 1'b1);
            applyStimulus("stream", 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        end

        // Stall with a hit at 0x10: skid captures, latch frozen for three cycles
        for (int i = 0; i < 3; i++) begin
            pushExp(1'b1, tagOf(32'h0C), 32'h10, 32'h14, 1'b0);
            applyStimulus("hold", 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        end
        pushExp(1'b1, tagOf(32'h10), 32'h14, 32'h14, 1'b1);
        applyStimulus("unstall", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        pushExp(1'b1, tagOf(32'h14), 32'h18, 32'h18, 1'b1);
        applyStimulus("resume", 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);

        // Redirect while holding discards the buffered word
        pushExp(1'b1, tagOf(32'h14), 32'h18, 32'h1C, 1'b0);
        applyStimulus("hold2", 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        pushExp(1'b0, 32'd0, 32'd0, 32'h200, 1'b1);
        applyStimulus("redirHold", 1'b0, 1'b1, 1'b0, 1'b1, 32'h200, 1'b0);
        pushExp(1'b1, tagOf(32'h200), 32'h204, 32'h204, 1'b1);
        applyStimulus("afterRedir", 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);

        // Redirect drops a concurrent hit; flush+stall with hit still advances PC
        pushExp(1'b0, 32'd0, 32'd0, 32'h40, 1'b1);
        applyStimulus("redirHit", 1'b1, 1'b0, 1'b0, 1'b1, 32'h40, 1'b0);
        pushExp(1'b0, 32'd0, 32'd0, 32'h44, 1'b1);
        applyStimulus("flushStall", 1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
        pushExp(1'b1, tagOf(32'h44), 32'h48, 32'h48, 1'b1);
        applyStimulus("afterFlush", 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);

        // PC wrap at the top of the address space
        pushExp(1'b0, 32'd0, 32'd0, 32'hFFFF_FFFC, 1'b1);
        applyStimulus("redirTop", 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
        pushExp(1'b1, tagOf(32'hFFFF_FFFC), 32'h0, 32'h0, 1'b1);
        applyStimulus("wrap", 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        pushExp(1'b1, tagOf(32'h0), 32'h4, 32'h4, 1'b1);
        applyStimulus("postWrap", 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        pushExp(1'b1, tagOf(32'h0), 32'h4, 32'h4, 1'b1);
        applyStimulus("missStall", 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);

        // Halt beats redirect and then ignores everything
        pushExp(1'b0, 32'd0, 32'd0, 32'h4, 1'b0);
        applyStimulus("haltRedir", 1'b1, 1'b0, 1'b0, 1'b1, 32'h300, 1'b1);
        pushExp(1'b0, 32'd0, 32'd0, 32'h4, 1'b0);
        applyStimulus("halted1", 1'b1, 1'b0, 1'b1, 1'b1, 32'h500, 1'b0);
        pushExp(1'b0, 32'd0, 32'd0, 32'h4, 1'b0);
        applyStimulus("halted2", 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);

        // Asynchronous reset pulse out of HALTED
        ihit     = 1'b0;
        stallFD  = 1'b0;
        redirect = 1'b0;
        flushFD  = 1'b0;
        #2;
        nRST = 1'b0;
        #1;
        pushExp(1'b0, 32'd0, 32'd0, 32'd0, 1'b1);
        checkOutput("resetHalted");
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        pushExp(1'b1, tagOf(32'h0), 32'h4, 32'h4, 1'b1);
        applyStimulus("restart", 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);

        // Reset in HOLD loses the buffered word
        pushExp(1'b1, tagOf(32'h0), 32'h4, 32'h8, 1'b0);
        applyStimulus("holdAgain", 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        #2;
        nRST = 1'b0;
        #1;
        pushExp(1'b0, 32'd0, 32'd0, 32'd0, 1'b1);
        checkOutput("resetHold");
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        pushExp(1'b0, 32'd0, 32'd0, 32'd0, 1'b1);
        applyStimulus("noSkidLeak", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
